// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor_dataflow.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_dataflow (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per cycle, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bit_d, bit_bout;

  full_subtractor_dataflow u_fsub (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Next-state logic: capture, shift one bit per cycle, then publish the result.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d = (res_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
        bin_d = bit_bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_d == CntMax) begin
          state_d = StDone;
        end
      end
      StDone: begin
        diff_d   = res_q;
        borrow_d = bin_q;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Busy is registered so it stays high through the cycle the done pulse is visible.
    busy_d = (state_d != StIdle) || (state_q == StDone);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8, diff8;
  logic [1:0] a2, b2, diff2;
  logic       busy8, done8, borrow8;
  logic       busy2, done2, borrow2;

  exp_t       q8[$];
  exp_t       q2[$];
  exp_t       e8, e2;
  int         checks = 0;
  int         failures = 0;
  int         ncyc = 0;
  logic       done8_prev = 1'b0;
  logic       done2_prev = 1'b0;
  logic [7:0] last_diff8 = '0;
  logic [1:0] last_diff2 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start2),
    .a      (a2),
    .b      (b2),
    .busy   (busy2),
    .done   (done2),
    .diff   (diff2),
    .borrow (borrow2)
  );

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  // Monitors: pop expected results when done pulses, checking value, latency and pulse width.
  always @(negedge clk) begin
    if (done8_prev) check("done8_width", done8, 0);
    if (done8) begin
      check("done8_expected", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        check("diff8", diff8, e8.diff);
        check("borrow8", borrow8, e8.borrow);
        check("latency8", ncyc, e8.cyc);
        check("busy8_at_done", busy8, 1);
        last_diff8 = e8.diff;
      end
    end
    done8_prev = done8;
  end

  always @(negedge clk) begin
    if (done2_prev) check("done2_width", done2, 0);
    if (done2) begin
      check("done2_expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        check("diff2", diff2, e2.diff[1:0]);
        check("borrow2", borrow2, e2.borrow);
        check("latency2", ncyc, e2.cyc);
        last_diff2 = e2.diff[1:0];
      end
    end
    done2_prev = done2;
  end

  task automatic wait8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
    check("drain8", q8.size(), 0);
  endtask

  task automatic wait2();
    for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
    check("drain2", q2.size(), 0);
  endtask

  // Issue one WIDTH=8 operation; operands are scrambled right after capture.
  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.diff   = x - y;
    e.borrow = (x < y);
    e.cyc    = ncyc + 10;
    start8 = 1'b1;
    a8 = x;
    b8 = y;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    check("busy8_run", busy8, 1);
    check("hold8", diff8, last_diff8);
    wait8();
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y);
    exp_t e;
    e.diff   = {6'd0, 2'(x - y)};
    e.borrow = (x < y);
    e.cyc    = ncyc + 4;
    start2 = 1'b1;
    a2 = x;
    b2 = y;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    a2 = 2'($urandom);
    b2 = 2'($urandom);
    check("busy2_run", busy2, 1);
    check("hold2", diff2, last_diff2);
    wait2();
  endtask

  initial begin
    int p;
    rst_n = 1'b0;
    start8 = 1'b0;
    start2 = 1'b0;
    a8 = '0;
    b8 = '0;
    a2 = '0;
    b2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_borrow8", borrow8, 0);
    check("rst_state8", dut8.state_q, StIdle);
    check("rst_busy2", busy2, 0);
    check("rst_state2", dut2.state_q, StIdle);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and boundary operand patterns.
    op8(8'd10, 8'd3);
    op8(8'd3, 8'd10);
    op8(8'h00, 8'hFF);
    op8(8'h00, 8'h00);
    op8(8'hFF, 8'h00);
    for (int i = 0; i < 4; i++) op8(8'($urandom), 8'($urandom));

    // Held start: back-to-back operations, operands changed mid-flight.
    p = ncyc;
    start8 = 1'b1;
    a8 = 8'd20;
    b8 = 8'd5;
    q8.push_back('{diff: 8'd15, borrow: 1'b0, cyc: p + 10});
    q8.push_back('{diff: 8'hFF, borrow: 1'b1, cyc: p + 20});
    repeat (2) @(negedge clk);
    a8 = 8'd1;
    b8 = 8'd2;
    for (int i = 0; i < 20 && ncyc < p + 11; i++) @(negedge clk);
    start8 = 1'b0;
    wait8();

    // Reset at edge 4 of an operation aborts it with no done pulse.
    p = ncyc;
    start8 = 1'b1;
    a8 = 8'd50;
    b8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 10 && ncyc < p + 4; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy8", busy8, 0);
    check("abort_diff8", diff8, 0);
    check("abort_done8", done8, 0);
    check("abort_borrow8", borrow8, 0);
    rst_n = 1'b1;
    last_diff8 = '0;
    last_diff2 = '0;
    repeat (15) @(negedge clk);
    op8(8'd100, 8'd1);

    // WIDTH=2 exhaustive.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) op2(2'(x), 2'(y));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, gives the operand and result width in bits; legal range is 1 to 32.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 Port start, input, 1 bit: the operation request, sampled only in IDLE.
REQ-005 Port a, input, WIDTH bits: the unsigned minuend, captured on the edge that accepts start.
REQ-006 Port b, input, WIDTH bits: the unsigned subtrahend, captured on the same edge as a.
REQ-007 Port busy, output, 1 bit: high in states SHIFT and DONE.
REQ-008 Port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-009 Port diff, output, WIDTH bits: the result a - b modulo 2^WIDTH.
REQ-010 Port borrow, output, 1 bit: the final borrow out; high iff a < b (unsigned).

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-012 IDLE: on an edge with start=1, the block SHALL load a and b into shift registers, clear the borrow flop and the bit counter, and go to SHIFT; with start=0 it stays in IDLE.
REQ-013 SHIFT: each edge SHALL process one bit pair, LSB first.
- d = a0 ^ b0 ^ bin
- bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
- d shifts into the result register from the MSB end; both operand registers shift right.
REQ-014 SHIFT SHALL last exactly WIDTH cycles; the counter SHALL be $clog2(WIDTH+1) bits, and the FSM goes to DONE when the counter reaches WIDTH.
REQ-015 DONE: diff and borrow SHALL update from the result register and borrow flop; done=1 for this single cycle; next state is IDLE unconditionally.
REQ-016 Latency: if start is accepted at edge 0, done SHALL be high for the cycle following edge WIDTH+1; busy SHALL be high from after edge 0 through that cycle.
REQ-017 start SHALL be ignored in SHIFT and DONE; a held-high start SHALL give back-to-back operations every WIDTH+2 cycles.
REQ-018 diff and borrow SHALL hold their last values until the next DONE, and SHALL never change mid-operation.
REQ-019 Changes on a or b after capture SHALL have no effect on the operation in flight.
REQ-020 WIDTH=1 SHALL operate correctly: one SHIFT cycle, with done after edge 2.

Reset
REQ-021 While rst_n=0 at a clock edge, the block SHALL take these values:
- state IDLE;
- busy=0, done=0, diff=0, borrow=0;
- shift registers, counter and borrow flop all 0.
REQ-022 A reset during SHIFT or DONE SHALL abort the operation with no done pulse; the first start after rst_n returns high SHALL behave as from power-up.

Structure
REQ-023 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in a shared include/package, so the FSM and the bench decode them identically.
REQ-024 The per-bit arithmetic SHALL be a separate combinational sub-module, full_subtractor_dataflow, with ports a, b, bin, d, bout; the top instantiates it once.

Verification
REQ-025 Case 1: WIDTH=8, a=8'd10, b=8'd3, start pulse at edge 0 -> done after edge 9, diff=8'd7, borrow=0.
REQ-026 Case 2: a=8'd3, b=8'd10 -> diff=8'hF9, borrow=1; also a=8'h00, b=8'hFF -> diff=8'h01, borrow=1; also a=b=0 -> diff=0, borrow=0.
REQ-027 Case 3: start held high with a=8'd20, b=8'd5, and operands changed to 8'd1, 8'd2 during SHIFT -> first done gives diff=8'd15, borrow=0; the next done comes 10 cycles later and gives diff=8'hFF, borrow=1.
REQ-028 Case 4: rst_n=0 for one edge at edge 4 of an operation -> busy=0 and diff=0 next cycle, with no done pulse.
REQ-029 Case 5: WIDTH=2, all 16 operand pairs -> every result matches the a - b reference model, and each done pulse is exactly one cycle wide.
